// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor control.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level single-bit full subtractor: d = a - b - b_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first, one bit per clock, using a
// single full-subtractor cell and a stored borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic fs_d;
    logic fs_b_out;
    logic last_bit;

    full_subtractor u_full_subtractor (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .b_in  (borrow_q),
        .d     (fs_d),
        .b_out (fs_b_out)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Datapath next-state: load on accepted start, one subtract/shift step per SHIFT cycle
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        ovf_d        = ovf_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                end
            end
            StShift: begin
                res_d    = {fs_d, res_q[WIDTH-1:1]};
                a_d      = {1'b0, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = fs_b_out;
                cnt_d    = cnt_q + CntW'(1);
                // On the final bit fs_d is the result MSB, so flags can be set here
                if (last_bit) begin
                    borrow_out_d = fs_b_out;
                    ovf_d        = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            ovf_q        <= ovf_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
        end
    end

    assign diff       = res_q;
    assign borrow_out = borrow_out_q;
    assign ovf        = ovf_q;

endmodule
